// File: rtl/eth_axil_regs_if.sv
// AXI-Lite bus between the Ethernet stack's UDP bridge (master) and its register bank (slave).
// 32-bit address and data, 4-bit byte strobe.
interface AXIL_IF;
  // Every channel moves one beat on a rising edge where valid and ready are both high.
  // Once valid is raised, it and its payload stay put until that edge.
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport Slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport Master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/eth_axil_regs.sv
// Network configuration register bank behind the Ethernet stack's UDP-to-AXI-Lite bridge.
// Define ETH_AXIL_REGS_STATS_EN to add the rx_good/rx_bad/tx_good frame counters.
module eth_axil_regs #(
  parameter logic [47:0] DEFAULT_MAC     = 48'h02_00_00_00_00_01,
  parameter logic [31:0] DEFAULT_IP      = 32'hC0A8_0180,
  parameter logic [31:0] DEFAULT_GATEWAY = 32'hC0A8_0101,
  parameter logic [31:0] DEFAULT_SUBNET  = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        reset_n,
  AXIL_IF.Slave       axil_if,
  output logic [47:0] local_mac,
  output logic [31:0] local_ip,
  output logic [31:0] gateway_ip,
  output logic [31:0] subnet_mask,
  output logic        clear_arp_cache,
  input  logic        rx_good_frame,
  input  logic        rx_bad_frame,
  input  logic        tx_good_frame
);

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [31:0] ID_VALUE    = 32'h4554_4801;

  localparam logic [5:0] IDX_ID      = 6'd0;
  localparam logic [5:0] IDX_CTRL    = 6'd1;
  localparam logic [5:0] IDX_MAC_LO  = 6'd2;
  localparam logic [5:0] IDX_MAC_HI  = 6'd3;
  localparam logic [5:0] IDX_IP      = 6'd4;
  localparam logic [5:0] IDX_GATEWAY = 6'd5;
  localparam logic [5:0] IDX_SUBNET  = 6'd6;
  localparam logic [5:0] IDX_SCRATCH = 6'd7;
`ifdef ETH_AXIL_REGS_STATS_EN
  localparam logic [5:0] IDX_RX_GOOD = 6'd8;
  localparam logic [5:0] IDX_RX_BAD  = 6'd9;
  localparam logic [5:0] IDX_TX_GOOD = 6'd10;
`endif

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v, input logic [31:0] new_v,
                                              input logic [3:0] strb);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  logic        aw_full, w_full, b_pend;
  logic        aw_full_n, w_full_n, b_pend_n, bvalid_n, rvalid_n;
  logic [5:0]  aw_idx;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic [31:0] scratch;
  logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic        commit, ctrl_commit, wr_ok;
  logic [31:0] rd_data;
  logic [1:0]  rd_resp;

  assign aw_hs       = axil_if.awvalid && axil_if.awready;
  assign w_hs        = axil_if.wvalid && axil_if.wready;
  assign b_hs        = axil_if.bvalid && axil_if.bready;
  assign ar_hs       = axil_if.arvalid && axil_if.arready;
  assign r_hs        = axil_if.rvalid && axil_if.rready;
  assign commit      = aw_full && w_full;
  assign ctrl_commit = commit && (aw_idx == IDX_CTRL);

  always_comb begin
    wr_ok = 1'b0;
    case (aw_idx)
      IDX_CTRL, IDX_MAC_LO, IDX_MAC_HI, IDX_IP,
      IDX_GATEWAY, IDX_SUBNET, IDX_SCRATCH: wr_ok = 1'b1;
      default:                             wr_ok = 1'b0;
    endcase
  end

  // b_pend spaces bvalid one cycle after the commit edge; the readies stay low through it.
  always_comb begin
    aw_full_n = aw_full;
    w_full_n  = w_full;
    b_pend_n  = b_pend;
    bvalid_n  = axil_if.bvalid;
    rvalid_n  = axil_if.rvalid;
    if (aw_hs) aw_full_n = 1'b1;
    if (w_hs)  w_full_n  = 1'b1;
    if (commit) begin
      aw_full_n = 1'b0;
      w_full_n  = 1'b0;
      b_pend_n  = 1'b1;
    end
    if (b_pend) begin
      b_pend_n = 1'b0;
      bvalid_n = 1'b1;
    end else if (b_hs) begin
      bvalid_n = 1'b0;
    end
    if (ar_hs)     rvalid_n = 1'b1;
    else if (r_hs) rvalid_n = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      aw_full         <= 1'b0;
      w_full          <= 1'b0;
      b_pend          <= 1'b0;
      aw_idx          <= '0;
      w_data          <= '0;
      w_strb          <= '0;
      axil_if.awready <= 1'b0;
      axil_if.wready  <= 1'b0;
      axil_if.bvalid  <= 1'b0;
      axil_if.bresp   <= RESP_OKAY;
      axil_if.arready <= 1'b0;
      axil_if.rvalid  <= 1'b0;
      axil_if.rdata   <= '0;
      axil_if.rresp   <= RESP_OKAY;
    end else begin
      aw_full         <= aw_full_n;
      w_full          <= w_full_n;
      b_pend          <= b_pend_n;
      axil_if.bvalid  <= bvalid_n;
      axil_if.rvalid  <= rvalid_n;
      axil_if.awready <= !aw_full_n && !b_pend_n && !bvalid_n;
      axil_if.wready  <= !w_full_n && !b_pend_n && !bvalid_n;
      axil_if.arready <= !rvalid_n;
      if (aw_hs) aw_idx <= axil_if.awaddr[7:2];
      if (w_hs) begin
        w_data <= axil_if.wdata;
        w_strb <= axil_if.wstrb;
      end
      if (commit) axil_if.bresp <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      if (ar_hs) begin
        axil_if.rdata <= rd_data;
        axil_if.rresp <= rd_resp;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      local_mac       <= DEFAULT_MAC;
      local_ip        <= DEFAULT_IP;
      gateway_ip      <= DEFAULT_GATEWAY;
      subnet_mask     <= DEFAULT_SUBNET;
      scratch         <= '0;
      clear_arp_cache <= 1'b0;
    end else begin
      clear_arp_cache <= ctrl_commit && w_strb[0] && w_data[0];
      if (commit) begin
        case (aw_idx)
          IDX_MAC_LO:  local_mac[31:0] <= merge_bytes(local_mac[31:0], w_data, w_strb);
          IDX_MAC_HI: begin
            if (w_strb[0]) local_mac[39:32] <= w_data[7:0];
            if (w_strb[1]) local_mac[47:40] <= w_data[15:8];
          end
          IDX_IP:      local_ip    <= merge_bytes(local_ip, w_data, w_strb);
          IDX_GATEWAY: gateway_ip  <= merge_bytes(gateway_ip, w_data, w_strb);
          IDX_SUBNET:  subnet_mask <= merge_bytes(subnet_mask, w_data, w_strb);
          IDX_SCRATCH: scratch     <= merge_bytes(scratch, w_data, w_strb);
          default: ;
        endcase
      end
    end
  end

`ifdef ETH_AXIL_REGS_STATS_EN
  logic [31:0] cnt_rx_good, cnt_rx_bad, cnt_tx_good;
  logic        cnt_clear;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic ev);
    return (ev && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  assign cnt_clear = ctrl_commit && w_strb[0] && w_data[1];

  // A clear on the same edge as an event leaves the counter at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_rx_good <= '0;
      cnt_rx_bad  <= '0;
      cnt_tx_good <= '0;
    end else if (cnt_clear) begin
      cnt_rx_good <= '0;
      cnt_rx_bad  <= '0;
      cnt_tx_good <= '0;
    end else begin
      cnt_rx_good <= sat_inc(cnt_rx_good, rx_good_frame);
      cnt_rx_bad  <= sat_inc(cnt_rx_bad, rx_bad_frame);
      cnt_tx_good <= sat_inc(cnt_tx_good, tx_good_frame);
    end
  end
`else
  logic unused_events;
  assign unused_events = rx_good_frame ^ rx_bad_frame ^ tx_good_frame;
`endif

  // Reads sample the registers before any same-edge commit, so they return the old value.
  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (axil_if.araddr[7:2])
      IDX_ID:      rd_data = ID_VALUE;
      IDX_CTRL:    rd_data = '0;
      IDX_MAC_LO:  rd_data = local_mac[31:0];
      IDX_MAC_HI:  rd_data = {16'h0000, local_mac[47:32]};
      IDX_IP:      rd_data = local_ip;
      IDX_GATEWAY: rd_data = gateway_ip;
      IDX_SUBNET:  rd_data = subnet_mask;
      IDX_SCRATCH: rd_data = scratch;
`ifdef ETH_AXIL_REGS_STATS_EN
      IDX_RX_GOOD: rd_data = cnt_rx_good;
      IDX_RX_BAD:  rd_data = cnt_rx_bad;
      IDX_TX_GOOD: rd_data = cnt_tx_good;
`endif
      default:     rd_resp = RESP_SLVERR;
    endcase
  end

  logic unused_addr;
  assign unused_addr = ^{axil_if.awaddr[31:8], axil_if.awaddr[1:0],
                         axil_if.araddr[31:8], axil_if.araddr[1:0]};

endmodule
